hpram_rst_seq: RTL and testbench

Power-up and recovery sequencer for the HyperRAM clock domain, on the consumer side of the 27 MHz to 150 MHz PLL. It drives the PLL reset, qualifies the asynchronous PLL lock, then releases the HyperRAM controller reset and waits for calibration. If lock is lost or a stage times out, it re-runs the sequence a bounded number of times. It runs on the free-running 27 MHz crystal clock, so it keeps operating while the PLL output is absent.

---
 rtl/hpram_rst_seq.sv | 162 ++++++++++++++++
 tb/tb_hpram_rst_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hpram_rst_seq.sv
// hpram_rst_seq
// Power-up and recovery sequencer for the HyperRAM clock domain. Runs on the
// free-running 27 MHz crystal clock so it keeps working while the PLL output
// is absent. Pulses the PLL reset, qualifies the (asynchronous) PLL lock,
// releases the HyperRAM controller reset, waits for calibration, and re-runs
// the bring-up a bounded number of times on lock loss or stage timeout.
//
// Ports
//   I_clk         in   27 MHz reference clock
//   I_rst_n       in   asynchronous active-low reset
//   I_pll_lock    in   PLL LOCK, asynchronous to I_clk
//   I_calib_done  in   controller calibration complete, asynchronous
//   O_pll_rst     out  PLL RESET pin, active high
//   O_mem_rst_n   out  HyperRAM controller reset, active low
//   O_ready       out  memory subsystem usable
//   O_fail        out  retries exhausted (terminal until I_rst_n)
//   O_retry_cnt   out  retries used in the current bring-up
module hpram_rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int CALIB_TIMEOUT      = 262144,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_pll_lock,
  input  logic       I_calib_done,
  output logic       O_pll_rst,
  output logic       O_mem_rst_n,
  output logic       O_ready,
  output logic       O_fail,
  output logic [1:0] O_retry_cnt
);

  // One shared stage counter covers the PLL reset pulse and both timeouts;
  // it only has to reach the largest terminal count.
  localparam int TMO_MAX = (LOCK_TIMEOUT > CALIB_TIMEOUT) ?
                           ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES) :
                           ((CALIB_TIMEOUT > PLL_RST_CYCLES) ? CALIB_TIMEOUT : PLL_RST_CYCLES);
  localparam int TMO_W = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
  localparam int STB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [TMO_W-1:0] RST_LAST   = TMO_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] LOCK_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] CALIB_LAST = TMO_W'(CALIB_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST   = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_CALIB,
    ST_RUN,
    ST_FAIL
  } state_t;

  logic             lock_meta_q, lock_s_q;
  logic             calib_meta_q, calib_s_q;
  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [1:0]       retry_cnt_q, retry_cnt_d;
  logic             pll_rst_q, mem_rst_n_q, ready_q, fail_q;
  logic             do_retry;

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    stable_cnt_d = '0;
    retry_cnt_d  = retry_cnt_q;
    do_retry     = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        tmo_cnt_d    = tmo_cnt_q + TMO_W'(1);
        // Any synced low cycle restarts qualification; the timeout keeps running.
        stable_cnt_d = lock_s_q ? stable_cnt_q + STB_W'(1) : '0;
        if (lock_s_q && stable_cnt_q == STB_LAST) state_d = ST_CALIB;
        else if (tmo_cnt_q == LOCK_LAST)          do_retry = 1'b1;
      end
      ST_CALIB: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (!lock_s_q) begin
          do_retry = 1'b1;
        end else if (calib_s_q) begin
          state_d     = ST_RUN;
          retry_cnt_d = '0;
        end else if (tmo_cnt_q == CALIB_LAST) begin
          do_retry = 1'b1;
        end
      end
      ST_RUN: begin
        // A later calib_done fall is deliberately ignored here.
        if (!lock_s_q) do_retry = 1'b1;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    if (do_retry) begin
      if (retry_cnt_q == RETRY_MAX) begin
        state_d = ST_FAIL;
      end else begin
        retry_cnt_d = retry_cnt_q + 2'd1;
        state_d     = ST_PLL_RST;
      end
    end

    if (state_d != state_q) begin
      tmo_cnt_d    = '0;
      stable_cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet still
  // change on the same edge as the state itself.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      calib_meta_q <= 1'b0;
      calib_s_q    <= 1'b0;
      state_q      <= ST_PLL_RST;
      tmo_cnt_q    <= '0;
      stable_cnt_q <= '0;
      retry_cnt_q  <= '0;
      pll_rst_q    <= 1'b1;
      mem_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      lock_meta_q  <= I_pll_lock;
      lock_s_q     <= lock_meta_q;
      calib_meta_q <= I_calib_done;
      calib_s_q    <= calib_meta_q;
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      pll_rst_q    <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      mem_rst_n_q  <= (state_d == ST_CALIB) || (state_d == ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fail_q       <= (state_d == ST_FAIL);
    end
  end

  assign O_pll_rst   = pll_rst_q;
  assign O_mem_rst_n = mem_rst_n_q;
  assign O_ready     = ready_q;
  assign O_fail      = fail_q;
  assign O_retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_hpram_rst_seq.sv
// Directed bench for hpram_rst_seq with small parameters
// (stable 8, timeouts 64, PLL reset 4, retries 3).
// Observed output word: {pll_rst, mem_rst_n, ready, fail, retry_cnt[1:0]}.
module tb_hpram_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       calib_done;
  logic       pll_rst;
  logic       mem_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [5:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  hpram_rst_seq #(
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT      (64),
    .CALIB_TIMEOUT     (64),
    .PLL_RST_CYCLES    (4),
    .MAX_RETRIES       (3)
  ) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_pll_lock  (pll_lock),
    .I_calib_done(calib_done),
    .O_pll_rst   (pll_rst),
    .O_mem_rst_n (mem_rst_n),
    .O_ready     (ready),
    .O_fail      (fail),
    .O_retry_cnt (retry_cnt)
  );

  assign obs = {pll_rst, mem_rst_n, ready, fail, retry_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cycles;
    logic       lock;
    logic       calib;
    logic [5:0] exp;
  } vec_t;

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (pll_rst,mem_rst_n,ready,fail,retry)", name, obs, exp);
    end else begin
      $display("check %s: outputs %b ok", name, obs);
    end
  endtask

  // Hold reset for three edges, check the reset state, release just after an
  // edge; the following edge is E1 of the new bring-up.
  task automatic reset_and_release(input logic lock, input logic calib);
    rst_n      = 1'b0;
    pll_lock   = lock;
    calib_done = calib;
    step(3);
    chk("reset_state", 6'b100000);
    rst_n = 1'b1;
  endtask

  vec_t vecs[15];

  initial begin
    // Clean bring-up, calib fall ignored in RUN, lock loss in RUN, then a
    // second bring-up that clears the retry count on reaching RUN.
    vecs[0]  = '{3, 1'b1, 1'b0, 6'b100000};
    vecs[1]  = '{1, 1'b1, 1'b0, 6'b000000};
    vecs[2]  = '{7, 1'b1, 1'b0, 6'b000000};
    vecs[3]  = '{1, 1'b1, 1'b0, 6'b010000};
    vecs[4]  = '{2, 1'b1, 1'b1, 6'b010000};
    vecs[5]  = '{1, 1'b1, 1'b1, 6'b011000};
    vecs[6]  = '{5, 1'b1, 1'b0, 6'b011000};
    vecs[7]  = '{2, 1'b0, 1'b0, 6'b011000};
    vecs[8]  = '{1, 1'b0, 1'b0, 6'b100001};
    vecs[9]  = '{3, 1'b1, 1'b0, 6'b100001};
    vecs[10] = '{1, 1'b1, 1'b0, 6'b000001};
    vecs[11] = '{7, 1'b1, 1'b0, 6'b000001};
    vecs[12] = '{1, 1'b1, 1'b0, 6'b010001};
    vecs[13] = '{2, 1'b1, 1'b1, 6'b010001};
    vecs[14] = '{1, 1'b1, 1'b1, 6'b011000};

    rst_n      = 1'b0;
    pll_lock   = 1'b0;
    calib_done = 1'b0;

    reset_and_release(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      pll_lock   = vecs[i].lock;
      calib_done = vecs[i].calib;
      step(vecs[i].cycles);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Lock glitch at stable count 5 (after E9): synced low at E12, so CALIB
    // moves from E12 to E20.
    reset_and_release(1'b1, 1'b0);
    step(9);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(2);
    chk("glitch_no_early_calib", 6'b000000);
    step(7);
    chk("glitch_before_calib", 6'b000000);
    step(1);
    chk("glitch_calib_entered", 6'b010000);

    // Lock never asserts: three 4-cycle retries, then FAIL holds.
    reset_and_release(1'b0, 1'b0);
    step(4);
    chk("nolock_wait_entered", 6'b000000);
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] r;
      r = 2'(i);
      step(63);
      chk($sformatf("nolock_pre_tmo%0d", i), {4'b0000, 2'(i - 1)});
      step(1);
      if (i < 4) begin
        chk($sformatf("nolock_retry%0d", i), {4'b1000, r});
        step(3);
        chk($sformatf("nolock_rst_hold%0d", i), {4'b1000, r});
        step(1);
        chk($sformatf("nolock_rst_end%0d", i), {4'b0000, r});
      end else begin
        chk("nolock_fail", 6'b100111);
        step(20);
        chk("nolock_fail_hold", 6'b100111);
      end
    end

    // Asynchronous reset in FAIL, mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_fail", 6'b100000);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("fail_restart_pll_rst", 6'b100000);
    step(1);
    chk("fail_restart_wait", 6'b000000);

    // Calibration timeout, then success on the second attempt.
    reset_and_release(1'b1, 1'b0);
    step(12);
    chk("ctmo_calib_entered", 6'b010000);
    step(63);
    chk("ctmo_pre_timeout", 6'b010000);
    step(1);
    chk("ctmo_retry", 6'b100001);
    step(4);
    chk("ctmo_wait2", 6'b000001);
    step(8);
    chk("ctmo_calib2", 6'b010001);
    calib_done = 1'b1;
    step(3);
    chk("ctmo_run2", 6'b011000);

    // Lock falls in the same synced cycle that calib rises: lock loss wins.
    reset_and_release(1'b1, 1'b0);
    step(12);
    chk("same_calib_entered", 6'b010000);
    pll_lock   = 1'b0;
    calib_done = 1'b1;
    step(2);
    chk("same_still_calib", 6'b010000);
    step(1);
    chk("same_lock_wins", 6'b100001);

    // Asynchronous reset in CALIB, mid-cycle, then restart from PLL_RST.
    reset_and_release(1'b1, 1'b0);
    step(14);
    chk("rcal_in_calib", 6'b010000);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_calib", 6'b100000);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("rcal_restart_pll_rst", 6'b100000);
    step(1);
    chk("rcal_restart_wait", 6'b000000);
    step(8);
    chk("rcal_restart_calib", 6'b010000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
